// File: rtl/me_result_collector.sv
// Result collector for the full-search ME top: runs the req/ack handshake, turns the linear
// best-candidate index into a centred (dx,dy) vector and queues results. Option: ME_COLLECT_STATS_EN.
module me_result_collector #(
  parameter int unsigned TB_LENGTH    = 16,
  parameter int unsigned SW_LENGTH    = 64,
  parameter int unsigned PE_OUT_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned RANGE       = SW_LENGTH - TB_LENGTH + 1,
  localparam int unsigned CNT_WIDTH   = $clog2(RANGE * RANGE),
  localparam int unsigned SAD_WIDTH   = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH,
  localparam int unsigned MV_WIDTH    = $clog2(RANGE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MV_WIDTH-1:0]  out_dx,
  output logic [MV_WIDTH-1:0]  out_dy,
  output logic [SAD_WIDTH-1:0] out_sad,
  output logic [15:0]          blk_cnt,
  output logic [31:0]          sad_sum
);

  localparam int unsigned OFFSET = (RANGE - 1) / 2;
  localparam int unsigned YW     = $clog2(RANGE);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StRelease = 3'd2;
  localparam logic [2:0] StDiv     = 3'd3;
  localparam logic [2:0] StPush    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [YW-1:0]        y_q, y_d;
  logic [YW-1:0]        x_q, x_d;
  logic [SAD_WIDTH-1:0] sad_q, sad_d;
  logic [15:0]          blk_cnt_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  logic [MV_WIDTH-1:0]  mem_dx_q  [FIFO_DEPTH];
  logic [MV_WIDTH-1:0]  mem_dy_q  [FIFO_DEPTH];
  logic [SAD_WIDTH-1:0] mem_sad_q [FIFO_DEPTH];

  logic [MV_WIDTH-1:0]  push_dx, push_dy;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    y_d     = y_q;
    x_d     = x_q;
    sad_d   = sad_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !me_ack && (count_q < CW'(FIFO_DEPTH))) state_d = StReq;
      end
      StReq: begin
        if (me_ack) begin
          rem_d   = me_min_mvec;
          sad_d   = me_min_sad;
          y_d     = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!me_ack) state_d = StDiv;
      end
      StDiv: begin
        if (rem_q >= CNT_WIDTH'(RANGE)) begin
          // Out-of-range index: clamp to the far corner instead of overflowing y.
          if (y_q == YW'(RANGE - 1)) begin
            x_d     = YW'(RANGE - 1);
            state_d = StPush;
          end else begin
            rem_d = rem_q - CNT_WIDTH'(RANGE);
            y_d   = y_q + YW'(1);
          end
        end else begin
          x_d     = rem_q[YW-1:0];
          state_d = StPush;
        end
      end
      StPush: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      y_q       <= '0;
      x_q       <= '0;
      sad_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      x_q     <= x_d;
      sad_q   <= sad_d;
      if (push) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign push_dx = MV_WIDTH'(x_q) - MV_WIDTH'(OFFSET);
  assign push_dy = MV_WIDTH'(y_q) - MV_WIDTH'(OFFSET);
  assign pop     = (count_q != '0) && out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dx_q[i]  <= '0;
        mem_dy_q[i]  <= '0;
        mem_sad_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_dx_q[wr_ptr_q]  <= push_dx;
        mem_dy_q[wr_ptr_q]  <= push_dy;
        mem_sad_q[wr_ptr_q] <= sad_q;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign me_req    = (state_q == StReq);
  assign out_valid = (count_q != '0);
  assign out_dx    = mem_dx_q[rd_ptr_q];
  assign out_dy    = mem_dy_q[rd_ptr_q];
  assign out_sad   = mem_sad_q[rd_ptr_q];
  assign blk_cnt   = blk_cnt_q;

`ifdef ME_COLLECT_STATS_EN
  logic [31:0] sad_sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_sum_q <= '0;
    end else if (push) begin
      sad_sum_q <= sad_sum_q + 32'(sad_q);
    end
  end

  assign sad_sum = sad_sum_q;
`else
  assign sad_sum = '0;
`endif

endmodule
